sub_in_rq_stream: RTL and testbench

- Streaming coefficient-wise polynomial subtractor in Rq = Z_q[x]/(x^N - 1), with q = 2^Q_BITS.
- Inverse operation of the Add_in_Rq path. Computes out_i = (in1_i - in2_i) mod q for i = 0..N-1, one coefficient per accepted beat.
- Sits between coefficient RAM readers and the next Rq stage in the NTRU-HRSS KEM datapath.
- Frames exactly N coefficients per start, with valid/ready handshakes on both sides.

---
 rtl/sub_in_rq_stream.sv | 122 ++++++++++++
 tb/tb_sub_in_rq_stream.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_in_rq_stream.sv
`default_nettype none
// ============================================================================
//  Module      : sub_in_rq_stream
//  Description : Streaming coefficient-wise subtractor in Rq = Z_q[x]/(x^N-1),
//                q = 2^Q_BITS. One (in1 - in2) mod q result per accepted beat,
//                exactly N beats per start, valid/ready on both sides.
//                Optional macro SUB_IN_RQ_BORROW_EN adds a registered
//                borrow_o output flagging in1 < in2.
//  Revision    : 1.0 - initial release
// ============================================================================
module sub_in_rq_stream #(
    parameter int N      = 701,
    parameter int Q_BITS = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [Q_BITS-1:0] in1,
    input  logic [Q_BITS-1:0] in2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [Q_BITS-1:0] out,
    output logic              out_last,
    output logic              busy,
`ifdef SUB_IN_RQ_BORROW_EN
    output logic              borrow_o,
`endif
    output logic              done
);

    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic              w_accept;
    logic              w_consume;
    logic              w_is_last;
    logic [Q_BITS-1:0] w_diff;

    // Input side may move only when the output register is free or draining.
    assign in_ready  = (r_state == RUN) && (!out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_consume = out_valid && out_ready;
    assign w_is_last = (r_cnt == C_LAST_IDX);
    assign busy      = (r_state != IDLE);

    // Two's-complement subtract; the dropped carry is the mod-q reduction.
    assign w_diff = in1 + ~in2 + Q_BITS'(1);

    // Frame sequencing: counts accepted beats and emits done after the last is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_is_last) begin
                            r_state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (w_consume && out_last) begin
                        r_state <= IDLE;
                        done    <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Output register: loads on accept, clears on drain, holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (w_accept) begin
            out       <= w_diff;
            out_valid <= 1'b1;
            out_last  <= w_is_last;
        end else if (w_consume) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

`ifdef SUB_IN_RQ_BORROW_EN
    // Borrow flag travels with the result it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            borrow_o <= 1'b0;
        end else if (w_accept) begin
            borrow_o <= (in1 < in2);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sub_in_rq_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sub_in_rq_stream
//  Description : Self-checking bench for sub_in_rq_stream: table vectors,
//                hand-written protocol sequences and a randomized frame
//                checked against a behavioural frame model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_in_rq_stream;

    localparam int N = 701;
    localparam int QB = 13;
    localparam int Q = 8192;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [QB-1:0] in1 = '0;
    logic [QB-1:0] in2 = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [QB-1:0] out;
    logic          out_last;
    logic          busy;
    logic          done;
`ifdef SUB_IN_RQ_BORROW_EN
    logic          borrow_o;
`endif

    sub_in_rq_stream #(.N(N), .Q_BITS(QB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .out_last(out_last), .busy(busy),
`ifdef SUB_IN_RQ_BORROW_EN
        .borrow_o(borrow_o),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Behavioural frame model: phase 0 idle, 1 collecting, 2 waiting for last drain.
    int m_phase = 0, m_cnt = 0, m_out = 0, m_ov = 0, m_olast = 0, m_done = 0, m_borrow = 0;
    int n_consumed = 0, n_done = 0, n_acc = 0;

    typedef struct {
        int a;
        int b;
        int exp;
        int brw;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_out = 0; m_ov = 0; m_olast = 0; m_done = 0; m_borrow = 0;
    endtask

    // One clock with the inputs currently driven; checks in_ready before and outputs after.
    task automatic cycle();
        int exp_ready, d;
        bit acc, cons, brw;
        #1;
        exp_ready = (m_phase == 1 && (m_ov == 0 || out_ready)) ? 1 : 0;
        chk("in_ready", int'(in_ready), exp_ready);
        acc  = in_valid && (exp_ready == 1);
        cons = (m_ov != 0) && out_ready;
        if (out_valid && out_ready) n_consumed++;
        d   = ((int'(in1) - int'(in2)) % Q + Q) % Q;
        brw = (int'(in1) < int'(in2));
        @(posedge clk);
        m_done = 0;
        if (m_phase == 0 && start) begin
            m_phase = 1; m_cnt = 0;
        end else if (m_phase == 2 && cons && m_olast != 0) begin
            m_phase = 0; m_done = 1;
        end
        if (acc) begin
            m_out = d; m_ov = 1; m_olast = (m_cnt == N - 1) ? 1 : 0; m_borrow = brw;
            m_cnt++; n_acc++;
            if (m_cnt == N) m_phase = 2;
        end else if (cons) begin
            m_ov = 0; m_olast = 0;
        end
        #1;
        chk("out_valid", int'(out_valid), m_ov);
        if (m_ov != 0) begin
            chk("out", int'(out), m_out);
            chk("out_last", int'(out_last), m_olast);
`ifdef SUB_IN_RQ_BORROW_EN
            chk("borrow_o", int'(borrow_o), m_borrow);
`endif
        end
        chk("done", int'(done), m_done);
        chk("busy", int'(busy), (m_phase != 0) ? 1 : 0);
        if (done) n_done++;
    endtask

    task automatic pulse_start(input bit with_valid);
        start = 1'b1; in_valid = with_valid; in1 = 13'd7; in2 = 13'd1;
        cycle();
        start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out"}, int'(out), 0);
        chk({tag, "_out_last"}, int'(out_last), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_busy"}, int'(busy), 0);
`ifdef SUB_IN_RQ_BORROW_EN
        chk({tag, "_borrow_o"}, int'(borrow_o), 0);
`endif
    endtask

    // Drive until the frame's done pulse (mode 0: i/2i pattern, mode 1: random).
    // abort_at >= 0 resets the DUT once that many beats were accepted.
    task automatic run_frame(input int mode, input int abort_at);
        int stall = 0;
        int acc0 = n_acc;
        bit ended = 0;
        for (int k = 0; k < 6000 && !ended; k++) begin
            if (abort_at >= 0 && (n_acc - acc0) == abort_at) begin
                rst_n = 1'b0;
                #2;
                check_all_zero("midrst");
                model_reset();
                @(posedge clk); #1;
                rst_n = 1'b1;
                in_valid = 1'b0; start = 1'b0;
                return;
            end
            if (mode == 0) begin
                in_valid = 1'b1; out_ready = 1'b1;
                in1 = 13'(m_cnt); in2 = 13'((2 * m_cnt) % Q);
                if (m_phase == 2 && stall < 2) begin
                    out_ready = 1'b0; stall++;
                end
            end else begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
                in1 = 13'($urandom); in2 = 13'($urandom);
                start = ($urandom_range(0, 15) == 0);
            end
            cycle();
            start = 1'b0;
            if (m_done != 0) ended = 1;
        end
        in_valid = 1'b0;
        if (!ended) chk("frame_timeout", 0, 1);
    endtask

    initial begin
        tbl[0] = '{5, 3, 2, 0};
        tbl[1] = '{3, 5, 8190, 1};
        tbl[2] = '{0, 8191, 1, 1};
        tbl[3] = '{8191, 0, 8191, 0};
        tbl[4] = '{0, 0, 0, 0};
        tbl[5] = '{4096, 4097, 8191, 1};
        tbl[6] = '{100, 50, 50, 0};
        tbl[7] = '{0, 1, 8191, 1};

        // Reset state
        #13;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // in_valid before start is not consumed
        in_valid = 1'b1; out_ready = 1'b1; in1 = 13'd9; in2 = 13'd4;
        cycle(); cycle();
        in_valid = 1'b0;

        // start with in_valid in the same cycle: only the start is taken
        pulse_start(1'b1);

        // Table vectors, one per cycle at full throughput
        n_consumed = 0; n_done = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; out_ready = 1'b1;
            in1 = 13'(tbl[i].a); in2 = 13'(tbl[i].b);
            cycle();
            chk("tbl_out", int'(out), tbl[i].exp);
            chk("tbl_valid", int'(out_valid), 1);
`ifdef SUB_IN_RQ_BORROW_EN
            chk("tbl_borrow", int'(borrow_o), tbl[i].brw);
`endif
        end

        // Backpressure: result held, nothing accepted for 4 cycles
        out_ready = 1'b0; in_valid = 1'b1; in1 = 13'd1000; in2 = 13'd1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("bp_hold", int'(out), tbl[7].exp);
        end
        chk("bp_cnt", m_cnt, 8);

        // start while busy is ignored
        start = 1'b1; out_ready = 1'b1;
        cycle();
        start = 1'b0;
        chk("busy_start_cnt", m_cnt, 9);

        // Finish frame with i / 2i pattern, stalling twice in FLUSH
        run_frame(0, -1);
        chk("frameA_consumed", n_consumed, N);
        chk("frameA_done", n_done, 1);
        chk("frameA_idle", int'(busy), 0);

        // Clean full pattern frame
        pulse_start(1'b0);
        n_consumed = 0; n_done = 0;
        run_frame(0, -1);
        chk("frameB_consumed", n_consumed, N);
        chk("frameB_done", n_done, 1);

        // Randomized frame
        pulse_start(1'b0);
        n_consumed = 0; n_done = 0;
        run_frame(1, -1);
        chk("frameR_consumed", n_consumed, N);
        chk("frameR_done", n_done, 1);

        // Reset after 300 beats, then a clean frame from zero
        pulse_start(1'b0);
        run_frame(0, 300);
        out_ready = 1'b1;
        cycle();
        pulse_start(1'b0);
        n_consumed = 0; n_done = 0;
        run_frame(0, -1);
        chk("frameC_consumed", n_consumed, N);
        chk("frameC_done", n_done, 1);
        cycle();
        chk("final_idle", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
